// File: rtl/add_serial_sched_pkg.sv
// add_serial_pkg: shared types and constants for the serial-adder scheduler.
//   state_t        - scheduler FSM state encoding (3-bit)
//   ADD_SERIAL_W   - default operand/result width
//   ADD_SERIAL_LAT - default adder latency, load-enable cycle to stable sum
//   clog2()        - ceiling log2, usable in parameter expressions
package add_serial_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CAPT  = 3'd3,
    S_REL   = 3'd4
  } state_t;

  localparam int ADD_SERIAL_W   = 8;
  localparam int ADD_SERIAL_LAT = 9;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/add_serial_sched_if.sv
// add_serial_sched_if: client-side and adder-side signals of the scheduler.
//   req/a_in/b_in       - per-requester request level and packed operands
//   gnt/resp_vld        - one-hot grant and one-cycle result strobe
//   resp_data           - sum for the strobed requester
//   busy                - scheduler not idle
//   add_en/add_a/add_b  - drive to the shared serial adder
//   add_out             - result from the shared serial adder
// slave is the scheduler; master is the environment (clients plus adder).
interface add_serial_sched_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   gnt;
  logic [N-1:0]   resp_vld;
  logic [W-1:0]   resp_data;
  logic           busy;
  logic           add_en;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W-1:0]   add_out;

  modport master (
    output req, a_in, b_in, add_out,
    input  gnt, resp_vld, resp_data, busy, add_en, add_a, add_b
  );

  modport slave (
    input  req, a_in, b_in, add_out,
    output gnt, resp_vld, resp_data, busy, add_en, add_a, add_b
  );
endinterface

// File: rtl/add_serial_sched_rr_pick.sv
// rr_pick: combinational round-robin search.
//   i_req - request vector
//   i_ptr - highest-priority index this round
//   o_gnt - one-hot winner (zero if no request)
//   o_id  - binary winner index
//   o_any - at least one request present
// Searches upward from i_ptr and wraps N-1 -> 0.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_id,
  output logic           o_any
);
  always_comb begin
    int idx;
    o_gnt = '0;
    o_id  = '0;
    o_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(i_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!o_any && i_req[idx]) begin
        o_any      = 1'b1;
        o_gnt[idx] = 1'b1;
        o_id       = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/add_serial_sched.sv
// add_serial_sched: round-robin owner of one shared bit-serial adder.
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - slave side of add_serial_sched_if (clients + adder)
// Flow: IDLE picks a winner and latches its operands, ISSUE pulses add_en to
// load the adder, WAIT counts out the adder latency, CAPT samples the sum and
// strobes resp_vld, REL pulses add_en again to return the adder to idle.
module add_serial_sched
  import add_serial_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = ADD_SERIAL_W,
  parameter int ADD_LAT = ADD_SERIAL_LAT
) (
  input logic clk,
  input logic rst,
  add_serial_sched_if.slave bus
);
  localparam int IDW = (N > 1) ? clog2(N) : 1;
  // One spare bit so the counter never wraps before reaching ADD_LAT-1.
  localparam int CW  = clog2(ADD_LAT) + 1;

  state_t         r_state, w_next;
  logic [IDW-1:0] r_ptr, r_id, w_pick_id;
  logic [N-1:0]   w_pick_gnt, r_gnt, r_resp_vld;
  logic           w_pick_any;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_add_a, r_add_b, r_resp_data;
  logic           r_busy, w_add_en;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_id  (w_pick_id),
    .o_any (w_pick_any)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_pick_any) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (r_cnt == CW'(ADD_LAT - 1)) w_next = S_CAPT;
      S_CAPT:  w_next = S_REL;
      S_REL:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Adder enable: load pulse in ISSUE, release pulse in REL.
  always_comb begin
    w_add_en = (r_state == S_ISSUE) || (r_state == S_REL);
  end

  // Registered datapath and client-facing outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_gnt       <= '0;
      r_resp_vld  <= '0;
      r_resp_data <= '0;
      r_cnt       <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_resp_vld <= '0;
      r_busy     <= (w_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_pick_any) begin
            r_id    <= w_pick_id;
            r_gnt   <= w_pick_gnt;
            r_add_a <= bus.a_in[w_pick_id*W +: W];
            r_add_b <= bus.b_in[w_pick_id*W +: W];
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT:  if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        S_CAPT: begin
          r_resp_data <= bus.add_out;
          r_resp_vld  <= r_gnt;
          r_gnt       <= '0;
          r_ptr       <= (int'(r_id) == N - 1) ? '0 : r_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.resp_vld  = r_resp_vld;
  assign bus.resp_data = r_resp_data;
  assign bus.busy      = r_busy;
  assign bus.add_en    = w_add_en;
  assign bus.add_a     = r_add_a;
  assign bus.add_b     = r_add_b;
endmodule

// File: tb/tb_add_serial_sched.sv
module tb_add_serial_sched;
  localparam int N = 4;
  localparam int W = 8;
  localparam int LAT = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  add_serial_sched_if #(.N(N), .W(W)) bus();

  add_serial_sched #(.N(N), .W(W), .ADD_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural serial adder: load on add_en in idle, sum valid LAT cycles
  // after the load-enable cycle, held in done until a release add_en.
  int         m_st, m_cnt;
  logic [7:0] m_a, m_b;
  bit         m_err;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st <= 0; m_cnt <= 0; m_a <= '0; m_b <= '0; bus.add_out <= '0;
    end else begin
      case (m_st)
        0: if (bus.add_en) begin
             m_a <= bus.add_a; m_b <= bus.add_b; m_cnt <= 1; m_st <= 1;
             bus.add_out <= 8'hEE;
           end
        1: begin
             if (bus.add_en) m_err <= 1'b1;
             m_cnt <= m_cnt + 1;
             if (m_cnt + 1 == LAT) begin bus.add_out <= m_a + m_b; m_st <= 2; end
           end
        default: if (bus.add_en) m_st <= 0;
      endcase
    end
  end

  typedef struct { int id; logic [7:0] sum; } exp_t;
  exp_t sb[$];

  int         vectors = 0;
  int         miscompares = 0;
  int         obs_id[$];
  logic [7:0] obs_data[$];
  int         obs_cyc[$];
  int         gnt_cyc[$];
  logic [3:0] gnt_val[$];
  int         en_cnt;
  logic [3:0] prev_gnt;
  logic [7:0] lat_a, lat_b;
  bit         a_changed;

  task automatic clear_obs();
    obs_id.delete(); obs_data.delete(); obs_cyc.delete();
    gnt_cyc.delete(); gnt_val.delete(); sb.delete();
    en_cnt = 0; prev_gnt = '0; a_changed = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0; bus.a_in = '0; bus.b_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Observes the DUT for up to ncyc cycles; stops early after `target`
  // strobes. drop: requester releases req on seeing its resp_vld.
  task automatic collect(input int ncyc, input int target, input bit chg, input bit drop);
    int id;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (bus.add_en) en_cnt++;
      if (bus.gnt != 0 && prev_gnt == 0) begin
        gnt_cyc.push_back(cyc); gnt_val.push_back(bus.gnt);
        lat_a = bus.add_a; lat_b = bus.add_b;
      end else if ((bus.gnt != 0 || bus.resp_vld != 0) &&
                   (bus.add_a !== lat_a || bus.add_b !== lat_b)) a_changed = 1;
      prev_gnt = bus.gnt;
      if (bus.resp_vld != 0) begin
        id = -1;
        for (int k = 0; k < N; k++) if (bus.resp_vld == 4'(1 << k)) id = k;
        obs_id.push_back(id); obs_data.push_back(bus.resp_data); obs_cyc.push_back(cyc);
        if (drop) bus.req = bus.req & ~bus.resp_vld;
      end
      if (chg && bus.gnt != 0) begin bus.a_in = $urandom; bus.b_in = $urandom; end
      if (target > 0 && obs_id.size() >= target) begin bus.req = '0; break; end
    end
  endtask

  task automatic test_reset();
    bus.req = '0; bus.a_in = '0; bus.b_in = '0;
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (bus.gnt !== 4'h0) begin miscompares++; $display("FAIL reset_gnt got=%h exp=0", bus.gnt); end
    vectors++; if (bus.resp_vld !== 4'h0) begin miscompares++; $display("FAIL reset_vld got=%h exp=0", bus.resp_vld); end
    vectors++; if (bus.resp_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got=%h exp=0", bus.resp_data); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    vectors++; if (bus.add_en !== 1'b0) begin miscompares++; $display("FAIL reset_add_en got=%b exp=0", bus.add_en); end
    vectors++; if ({bus.add_a, bus.add_b} !== 16'h0) begin miscompares++; $display("FAIL reset_ops got=%h exp=0", {bus.add_a, bus.add_b}); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_single();
    exp_t e;
    do_reset(); clear_obs();
    bus.a_in[7:0] = 8'h35; bus.b_in[7:0] = 8'h4C; bus.req = 4'b0001;
    sb.push_back('{0, 8'h81});
    collect(25, 1, 0, 1);
    collect(5, 0, 0, 1);
    vectors++; if (gnt_cyc.size() != 1) begin miscompares++; $display("FAIL single_grants got=%0d exp=1", gnt_cyc.size()); end
    vectors++; if (obs_id.size() != 1) begin miscompares++; $display("FAIL single_resp_count got=%0d exp=1", obs_id.size()); end
    if (gnt_cyc.size() == 1 && obs_id.size() == 1) begin
      e = sb.pop_front();
      vectors++; if (gnt_val[0] !== 4'b0001) begin miscompares++; $display("FAIL single_gnt got=%b exp=0001", gnt_val[0]); end
      vectors++; if (lat_a !== 8'h35 || lat_b !== 8'h4C) begin miscompares++; $display("FAIL single_ops got=%h/%h exp=35/4c", lat_a, lat_b); end
      vectors++; if (obs_id[0] != e.id) begin miscompares++; $display("FAIL single_id got=%0d exp=%0d", obs_id[0], e.id); end
      vectors++; if (obs_data[0] !== e.sum) begin miscompares++; $display("FAIL single_sum got=%h exp=%h", obs_data[0], e.sum); end
      vectors++; if (obs_cyc[0] - gnt_cyc[0] != 11) begin miscompares++; $display("FAIL single_latency got=%0d exp=11", obs_cyc[0] - gnt_cyc[0]); end
    end
    vectors++; if (en_cnt != 2) begin miscompares++; $display("FAIL single_add_en_pulses got=%0d exp=2", en_cnt); end
  endtask

  task automatic test_round_robin();
    exp_t e;
    do_reset(); clear_obs();
    for (int i = 0; i < N; i++) begin
      bus.a_in[i*W +: W] = 8'(i + 1);
      bus.b_in[i*W +: W] = 8'(2 * (i + 1));
    end
    for (int k = 0; k < 5; k++) sb.push_back('{k % N, 8'(3 * ((k % N) + 1))});
    bus.req = 4'b1111;
    collect(100, 5, 0, 0);
    vectors++; if (obs_id.size() != 5) begin miscompares++; $display("FAIL rr_count got=%0d exp=5", obs_id.size()); end
    for (int k = 0; k < 5 && k < obs_id.size(); k++) begin
      e = sb.pop_front();
      vectors++; if (obs_id[k] != e.id || obs_data[k] !== e.sum) begin
        miscompares++; $display("FAIL rr_resp%0d got=%0d/%h exp=%0d/%h", k, obs_id[k], obs_data[k], e.id, e.sum);
      end
      if (k > 0) begin
        vectors++; if (obs_cyc[k] - obs_cyc[k-1] != 13) begin miscompares++; $display("FAIL rr_spacing%0d got=%0d exp=13", k, obs_cyc[k] - obs_cyc[k-1]); end
      end
    end
    collect(5, 0, 0, 0);
  endtask

  task automatic test_wrap_overflow();
    exp_t e;
    do_reset(); clear_obs();
    bus.a_in[2*W +: W] = 8'h11; bus.b_in[2*W +: W] = 8'h22; bus.req = 4'b0100;
    sb.push_back('{2, 8'h33});
    collect(30, 1, 0, 1);
    collect(2, 0, 0, 1);
    bus.a_in[3*W +: W] = 8'hFF; bus.b_in[3*W +: W] = 8'h02;
    bus.a_in[7:0] = 8'h10; bus.b_in[7:0] = 8'h20;
    bus.req = 4'b1001;
    sb.push_back('{3, 8'h01});
    sb.push_back('{0, 8'h30});
    collect(60, 3, 0, 1);
    vectors++; if (obs_id.size() != 3) begin miscompares++; $display("FAIL wrap_count got=%0d exp=3", obs_id.size()); end
    for (int k = 0; k < 3 && k < obs_id.size(); k++) begin
      e = sb.pop_front();
      vectors++; if (obs_id[k] != e.id || obs_data[k] !== e.sum) begin
        miscompares++; $display("FAIL wrap_resp%0d got=%0d/%h exp=%0d/%h", k, obs_id[k], obs_data[k], e.id, e.sum);
      end
    end
  endtask

  task automatic test_early_drop();
    exp_t e;
    clear_obs();
    bus.a_in[W +: W] = 8'h7A; bus.b_in[W +: W] = 8'h11; bus.req = 4'b0010;
    sb.push_back('{1, 8'h8B});
    collect(5, 0, 0, 1);
    bus.req = '0;
    collect(30, 1, 0, 1);
    collect(20, 0, 0, 1);
    vectors++; if (obs_id.size() != 1) begin miscompares++; $display("FAIL drop_resp_count got=%0d exp=1", obs_id.size()); end
    if (obs_id.size() >= 1) begin
      e = sb.pop_front();
      vectors++; if (obs_id[0] != e.id || obs_data[0] !== e.sum) begin
        miscompares++; $display("FAIL drop_resp got=%0d/%h exp=%0d/%h", obs_id[0], obs_data[0], e.id, e.sum);
      end
    end
    vectors++; if (gnt_cyc.size() != 1) begin miscompares++; $display("FAIL drop_phantom got=%0d grants exp=1", gnt_cyc.size()); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    clear_obs();
    bus.a_in[7:0] = 8'h05; bus.b_in[7:0] = 8'h06; bus.req = 4'b0001;
    collect(5, 0, 0, 1);
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before got=%b exp=1", bus.busy); end
    rst = 1'b1;
    #1;
    vectors++; if (bus.gnt !== 4'h0 || bus.busy !== 1'b0 || bus.resp_vld !== 4'h0 || bus.add_a !== 8'h00) begin
      miscompares++; $display("FAIL mid_reset got=gnt %b busy %b vld %b a %h exp=0", bus.gnt, bus.busy, bus.resp_vld, bus.add_a);
    end
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    collect(20, 0, 0, 1);
    vectors++; if (obs_id.size() != 0) begin miscompares++; $display("FAIL mid_no_resp got=%0d exp=0", obs_id.size()); end
    clear_obs();
    bus.a_in[2*W +: W] = 8'h40; bus.b_in[2*W +: W] = 8'h41; bus.req = 4'b0100;
    sb.push_back('{2, 8'h81});
    collect(30, 1, 0, 1);
    vectors++; if (obs_id.size() != 1) begin miscompares++; $display("FAIL mid_after_count got=%0d exp=1", obs_id.size()); end
    else begin
      e = sb.pop_front();
      vectors++; if (obs_id[0] != e.id || obs_data[0] !== e.sum) begin
        miscompares++; $display("FAIL mid_after got=%0d/%h exp=%0d/%h", obs_id[0], obs_data[0], e.id, e.sum);
      end
    end
  endtask

  task automatic test_operand_stability();
    exp_t e;
    collect(3, 0, 0, 1);
    clear_obs();
    bus.a_in[3*W +: W] = 8'h44; bus.b_in[3*W +: W] = 8'h55; bus.req = 4'b1000;
    sb.push_back('{3, 8'h99});
    collect(30, 1, 1, 1);
    vectors++; if (a_changed) begin miscompares++; $display("FAIL stable_ops got=changed exp=held"); end
    vectors++; if (lat_a !== 8'h44 || lat_b !== 8'h55) begin miscompares++; $display("FAIL stable_latch got=%h/%h exp=44/55", lat_a, lat_b); end
    vectors++; if (obs_id.size() != 1) begin miscompares++; $display("FAIL stable_count got=%0d exp=1", obs_id.size()); end
    else begin
      e = sb.pop_front();
      vectors++; if (obs_id[0] != e.id || obs_data[0] !== e.sum) begin
        miscompares++; $display("FAIL stable_resp got=%0d/%h exp=%0d/%h", obs_id[0], obs_data[0], e.id, e.sum);
      end
    end
  endtask

  task automatic test_adder_protocol();
    vectors++; if (m_err) begin miscompares++; $display("FAIL adder_protocol got=add_en during shift exp=none"); end
  endtask

  initial begin
    m_err = 0;
    clear_obs();
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_overflow();
    test_early_drop();
    test_reset_mid();
    test_operand_stability();
    test_adder_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/add_serial_sched.md
Name: add_serial_sched

Overview:
- Round-robin scheduler that shares one 8-bit bit-serial adder (en/a/b in, out result) among N requesters.
- Latches the winning requester's operands and sequences the adder's enable: one load pulse, then one release pulse.
- Waits a fixed adder latency, captures the sum and returns it to the winner with a one-cycle valid.
- Sits between the client blocks and the single shared adder instance.

Parameters:
N, 4, number of requesters (2..8)
W, 8, operand/result width
ADD_LAT, 9, cycles from the load-enable cycle to a stable add_out (inclusive of the adder's shift cycles)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
req  input  N  per-requester request level
a_in  input  N*W  operand A, requester i at [i*W +: W]
b_in  input  N*W  operand B, same packing
gnt  output  N  one-hot grant, held while requester is in service
resp_vld  output  N  one-hot, one-cycle result strobe
resp_data  output  W  sum for the strobed requester, held until next capture
busy  output  1  high whenever state is not S_IDLE
add_en  output  1  adder enable
add_a  output  W  adder operand A
add_b  output  W  adder operand B
add_out  input  W  adder result

Behaviour:
- Reset (async, rst=1) forces the following: state=S_IDLE, gnt=0, resp_vld=0, resp_data=0, busy=0, add_en=0, add_a=0, add_b=0, rr pointer=0, wait counter=0. Reset mid-operation abandons the transaction with no response. The adder is reset by the same rst.
- FSM states are S_IDLE, S_ISSUE, S_WAIT, S_CAPT, S_REL.
- S_IDLE:
  - If req!=0, select the winner: first set bit searching upward from ptr, wrapping N-1 to 0.
  - Register the winner id, latch a_in/b_in slices into add_a/add_b, set gnt one-hot, go to S_ISSUE.
  - If req==0, stay.
- S_ISSUE: add_en=1 for exactly this cycle; cnt<=0; go to S_WAIT.
- S_WAIT:
  - add_en=0; cnt increments each cycle.
  - When cnt==ADD_LAT-1, go to S_CAPT. cnt width is clog2(ADD_LAT)+1 with no wrap.
- S_CAPT:
  - resp_data<=add_out; resp_vld[id]=1 for one cycle.
  - ptr<=(id+1) mod N; gnt<=0; go to S_REL.
- S_REL: add_en=1 for exactly one cycle to return the adder from its done state to idle; go to S_IDLE.
- Latency:
  - Grant decision to resp_vld is ADD_LAT+2 cycles.
  - Back-to-back service costs ADD_LAT+4 cycles per operation.
  - The next arbitration happens in the S_IDLE cycle after S_REL.
- add_a/add_b hold their latched values from S_ISSUE through S_REL. Operand changes on a_in/b_in after latching are ignored.
- Requester protocol:
  - A requester holds req until it sees its resp_vld; it may deassert req in that same cycle.
  - If req drops while in service, the operation completes and resp_vld still fires.
  - req reasserted in the resp_vld cycle is eligible at the next S_IDLE, but loses to any other pending requester (pointer has moved past it).
- Arithmetic: sum is modulo 2^W with no carry-out. The scheduler passes add_out unmodified.
- All outputs are registered except add_en, which is decoded from state.

Decomposition:
- Package add_serial_pkg holds:
  - the state enum (S_IDLE..S_REL, 3-bit);
  - default constants ADD_SERIAL_W=8 and ADD_SERIAL_LAT=9;
  - a function clog2.
- Sub-module rr_pick (combinational, N-bit req + ptr in, one-hot grant + binary id out) holds the wrap-around priority search. It is instanced once.

Test Plan:
- Single requester: reset, then req=0001, a0=0x35, b0=0x4C. Required response: gnt=0001 in S_ISSUE, add_en pulses in S_ISSUE and S_REL only, resp_vld=0001 exactly 11 cycles after the grant cycle, resp_data=0x81.
- Round-robin fairness: req=1111 held, operands i+1 and 2(i+1). Required response: service order 0,1,2,3,0; sums 0x03, 0x06, 0x09, 0x0C; consecutive strobes 13 cycles apart.
- Wrap and overflow: ptr=3 after serving 2, req=1001, a3=0xFF, b3=0x02. Required response: requester 3 is served before 0; resp_data=0x01.
- Early req drop: requester 1 deasserts req in S_WAIT. Required response: resp_vld[1] still fires with the correct sum, and no phantom re-service follows.
- Reset mid-operation: assert rst during S_WAIT. Required response: next cycle gnt=0, busy=0, resp_vld=0, add_a=0, and no response follows. After release, req=0100 is served first with ptr=0.
- Operand stability: change a_in/b_in every cycle during service. Required response: add_a/add_b are constant from S_ISSUE to S_REL, and resp_data reflects the latched values.
